// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Constants and types shared by the shift datapath, the shift sequencer and
// the control unit.
//   - Opcode encodings for the four single-bit shift functions.
//   - Sequencer state encoding.
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [1:0] SHL_FN = 2'b00;  // logical shift left, C = bit out
  localparam logic [1:0] SHR_FN = 2'b01;  // logical shift right, C = bit out
  localparam logic [1:0] ROL_FN = 2'b10;  // rotate left, C untouched
  localparam logic [1:0] ROR_FN = 2'b11;  // rotate right, C untouched

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_t;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-bit shift/rotate step.
// Ports:
//   work        in   WIDTH  current working value
//   op          in   2      shift function (shift_pkg opcode constants)
//   next_work   out  WIDTH  value after one step
//   carry_out   out  1      bit shifted out (meaningful for SHL/SHR only)
//   carry_valid out  1      1 when carry_out should update the carry flag
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] work,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] next_work,
  output logic             carry_out,
  output logic             carry_valid
);

  // One-position shift or rotate selected by op.
  always_comb begin
    next_work   = work;
    carry_out   = 1'b0;
    carry_valid = 1'b0;
    case (op)
      SHL_FN: begin
        next_work   = {work[WIDTH-2:0], 1'b0};
        carry_out   = work[WIDTH-1];
        carry_valid = 1'b1;
      end
      SHR_FN: begin
        next_work   = {1'b0, work[WIDTH-1:1]};
        carry_out   = work[0];
        carry_valid = 1'b1;
      end
      ROL_FN: begin
        next_work   = {work[WIDTH-2:0], work[WIDTH-1]};
        carry_out   = 1'b0;
        carry_valid = 1'b0;
      end
      ROR_FN: begin
        next_work   = {work[0], work[WIDTH-1:1]};
        carry_out   = 1'b0;
        carry_valid = 1'b0;
      end
      default: begin
        next_work   = work;
        carry_out   = 1'b0;
        carry_valid = 1'b0;
      end
    endcase
  end

endmodule : shift_step

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle controller that drives the shift datapath one bit position per
// clock. An operation is accepted with start in IDLE; operands are latched,
// the selected function is applied count times, and the result plus carry
// and zero flags are presented with a one-cycle done pulse. The result stays
// stable until the next accepted operation.
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   start    in   1      operation request, sampled only in IDLE
//   opcode   in   2      shift function (shift_pkg constants)
//   count    in   CNT_W  number of single-bit steps
//   data_in  in   WIDTH  operand
//   busy     out  1      high while in SHIFT or FINISH
//   done     out  1      single-cycle pulse when result is valid
//   result   out  WIDTH  final shifted value
//   C        out  1      carry flag (last bit out for SHL/SHR, else 0)
//   Z        out  1      zero flag, result == 0
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             C,
  output logic             Z
);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [1:0]       op_q,     op_d;
  logic [CNT_W-1:0] rem_q,    rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q,      c_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] step_work;
  logic             step_carry;
  logic             step_carry_valid;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .work        (work_q),
    .op          (op_q),
    .next_work   (step_work),
    .carry_out   (step_carry),
    .carry_valid (step_carry_valid)
  );

  // Next-state and datapath update; result is only loaded on entry to FINISH.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    op_d     = op_q;
    rem_d    = rem_q;
    result_d = result_q;
    c_d      = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = data_in;
          op_d   = opcode;
          rem_d  = count;
          c_d    = 1'b0;
          if (count != {CNT_W{1'b0}}) begin
            state_d = SHIFT;
          end else begin
            // Zero-step operation: pass the operand straight through.
            state_d  = FINISH;
            result_d = data_in;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = step_work;
        if (step_carry_valid) begin
          c_d = step_carry;
        end else begin
          c_d = c_q;
        end
        // rem is at least 1 here, so the decrement never wraps.
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d  = FINISH;
          result_d = step_work;
        end else begin
          state_d = SHIFT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they align with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State, datapath and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= {WIDTH{1'b0}};
      op_q     <= SHL_FN;
      rem_q    <= {CNT_W{1'b0}};
      result_q <= {WIDTH{1'b0}};
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign C      = c_q;
  assign Z      = (result_q == {WIDTH{1'b0}});

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed testbench for shift_sequencer with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;
  import shift_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] opcode;
  logic [2:0] count;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       C;
  logic       Z;

  int tests_run;
  int tests_failed;
  int lat;
  int busy_cyc;
  int done_seen;
  int changed;

  shift_sequencer #(
    .WIDTH (8),
    .CNT_W (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .opcode  (opcode),
    .count   (count),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .C       (C),
    .Z       (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle. Presents one operation for a single edge,
  // scrambles the operand inputs afterwards, and waits (bounded) for done.
  // lat = number of rising edges from the accept edge (inclusive) to the
  // first cycle with done high; -1 if done never came.
  task automatic run_op(input logic [1:0] op, input logic [7:0] din,
                        input logic [2:0] cnt, output int lat_o, output int busy_o);
    lat_o  = -1;
    busy_o = 0;
    opcode  = op;
    data_in = din;
    count   = cnt;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    opcode  = ~op;
    data_in = ~din;
    count   = ~cnt;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_o++;
      if (done) begin
        lat_o = k;
        break;
      end
    end
  endtask

  // One cycle after done: the pulse must be gone and the block idle.
  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    start   = 1'b0;
    opcode  = SHL_FN;
    count   = 3'd0;
    data_in = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", {24'd0, result}, 32'h00);
    check("rst_C",      {31'd0, C},      32'd0);
    check("rst_Z",      {31'd0, Z},      32'd1);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SHL 0x81 by 1: 0x02, carry 1
    run_op(SHL_FN, 8'h81, 3'd1, lat, busy_cyc);
    check("shl1_lat",    32'(lat),        32'd2);
    check("shl1_busy",   32'(busy_cyc),   32'd2);
    check("shl1_result", {24'd0, result}, 32'h02);
    check("shl1_C",      {31'd0, C},      32'd1);
    check("shl1_Z",      {31'd0, Z},      32'd0);
    check_pulse_end("shl1");

    // SHR 0x01 by 1: 0x00, carry 1, zero
    run_op(SHR_FN, 8'h01, 3'd1, lat, busy_cyc);
    check("shr1_lat",    32'(lat),        32'd2);
    check("shr1_result", {24'd0, result}, 32'h00);
    check("shr1_C",      {31'd0, C},      32'd1);
    check("shr1_Z",      {31'd0, Z},      32'd1);
    check_pulse_end("shr1");

    // ROL 0x81 by 3: 0x03, 0x06, 0x0C
    run_op(ROL_FN, 8'h81, 3'd3, lat, busy_cyc);
    check("rol3_lat",    32'(lat),        32'd4);
    check("rol3_result", {24'd0, result}, 32'h0C);
    check("rol3_C",      {31'd0, C},      32'd0);
    check_pulse_end("rol3");

    // ROR 0x01 by 7 (max count): 0x02
    run_op(ROR_FN, 8'h01, 3'd7, lat, busy_cyc);
    check("ror7_lat",    32'(lat),        32'd8);
    check("ror7_busy",   32'(busy_cyc),   32'd8);
    check("ror7_result", {24'd0, result}, 32'h02);
    check("ror7_C",      {31'd0, C},      32'd0);
    check_pulse_end("ror7");

    // SHL 0xA5 by 0: pass-through, done next cycle
    run_op(SHL_FN, 8'hA5, 3'd0, lat, busy_cyc);
    check("cnt0_lat",    32'(lat),        32'd1);
    check("cnt0_result", {24'd0, result}, 32'hA5);
    check("cnt0_C",      {31'd0, C},      32'd0);
    check("cnt0_Z",      {31'd0, Z},      32'd0);
    check_pulse_end("cnt0");

    // Start held high with new operands during SHL 0x0F by 2 -> ignored
    opcode  = SHL_FN;
    data_in = 8'h0F;
    count   = 3'd2;
    start   = 1'b1;
    @(posedge clk);
    #1;
    opcode  = ROR_FN;
    data_in = 8'hFF;
    count   = 3'd5;
    lat     = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("ign_lat",    32'(lat),        32'd3);
    check("ign_result", {24'd0, result}, 32'h3C);
    check("ign_C",      {31'd0, C},      32'd0);
    check_pulse_end("ign");

    // SHL 0x40 by 2: 0x80 then 0x00 with carry 1; then hold for 10 cycles
    run_op(SHL_FN, 8'h40, 3'd2, lat, busy_cyc);
    check("hold_lat",    32'(lat),        32'd3);
    check("hold_result", {24'd0, result}, 32'h00);
    check("hold_C",      {31'd0, C},      32'd1);
    check("hold_Z",      {31'd0, Z},      32'd1);
    done_seen = 0;
    changed   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (result !== 8'h00 || C !== 1'b1 || Z !== 1'b1) changed++;
    end
    check("hold_no_done",  32'(done_seen), 32'd0);
    check("hold_stable",   32'(changed),   32'd0);

    // SHR 0x80 by 7: 0x01, last bit out 0
    run_op(SHR_FN, 8'h80, 3'd7, lat, busy_cyc);
    check("shr7_lat",    32'(lat),        32'd8);
    check("shr7_result", {24'd0, result}, 32'h01);
    check("shr7_C",      {31'd0, C},      32'd0);
    check("shr7_Z",      {31'd0, Z},      32'd0);
    check_pulse_end("shr7");

    // Reset in the middle of SHL 0xFF by 7: immediate return, no done
    opcode  = SHL_FN;
    data_in = 8'hFF;
    count   = 3'd7;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_result", {24'd0, result}, 32'h00);
    check("abort_C",      {31'd0, C},      32'd0);
    check("abort_Z",      {31'd0, Z},      32'd1);
    check("abort_busy",   {31'd0, busy},   32'd0);
    check("abort_done",   {31'd0, done},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_shift_sequencer

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit shift datapath, one bit position per clock.
- Replaces the edge-triggered shift_enable usage with a clocked start/busy/done handshake toward the control unit.
- Latches operands and iterates SHL/SHR/ROL/ROR count times.
- Presents result plus C/Z flags, held stable until the next accepted operation.

Parameters:
- WIDTH, 8, data path width in bits.
- CNT_W, 3, width of the shift count; maximum count is 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- opcode  input  2  shift function; SHL/SHR/ROL/ROR package constants.
- count  input  CNT_W  number of single-bit steps.
- data_in  input  WIDTH  operand.
- busy  output  1  high in SHIFT and FINISH.
- done  output  1  single-cycle pulse when result is valid.
- result  output  WIDTH  shifted value, held until the next accept.
- C  output  1  carry flag.
- Z  output  1  zero flag, equal to (result == 0).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, result=0, C=0, done=0, busy=0, internal count=0, so Z=1.
  - Applies immediately and aborts any operation in progress; no done pulse is produced for an aborted operation.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - busy=0, done=0.
  - On a rising edge with start=1: latch work<=data_in, op<=opcode, rem<=count, C<=0.
  - Next state is SHIFT if count!=0, else FINISH.
- SHIFT, one step per edge:
  - SHL: C<=work[7], work<={work[6:0],0}.
  - SHR: C<=work[0], work<={0,work[7:1]}.
  - ROL: work<={work[6:0],work[7]}, C unchanged (stays 0).
  - ROR: work<={work[0],work[7:1]}, C unchanged (stays 0).
  - rem<=rem-1. Transition to FINISH on the edge where rem==1; rem never wraps below 0.
- FINISH (one cycle):
  - done=1, busy=1.
  - result, C and Z reflect the final value.
  - Next edge goes to IDLE unconditionally.
- result output:
  - Registered copy of work, updated only on the edge entering FINISH.
  - Intermediate shift values are never visible on result.
  - Z is combinational from result.
- start handling:
  - Ignored in SHIFT and FINISH; no queuing.
  - Operand inputs are don't-care except on the accept edge.
- Latency:
  - done is asserted in the cycle beginning count+1 edges after the accept edge. count=0 gives done one cycle after accept.
  - Back-to-back throughput is one operation per count+2 cycles, because start must be re-presented in IDLE.
- Input changes after accept do not affect the operation in progress.
- C semantics: last bit shifted out for SHL/SHR; 0 for rotates and for count=0.

Decomposition:
- Shared package shift_pkg:
  - Opcode constants SHL_FN=2'b00, SHR_FN=2'b01, ROL_FN=2'b10, ROR_FN=2'b11.
  - State enum type {IDLE, SHIFT, FINISH}.
  - The existing shifter and the control unit import these same constants.
- Sub-module shift_step: purely combinational one-bit step, (work, op) -> (next_work, carry_out, carry_valid).
  - Instantiated once in the sequencer.
  - Testable standalone.

Test Plan:
- Reset then idle: after rst pulse -> result=0x00, C=0, Z=1, busy=0, done=0. Apply rst during SHIFT with count=7 -> outputs return to reset values immediately, no done pulse.
- SHL data_in=0x81, count=1, start one cycle -> busy high; done pulses 2 cycles after accept; result=0x02, C=1, Z=0.
- SHR data_in=0x01, count=1 -> result=0x00, C=1, Z=1. ROL 0x81 count=3 -> result=0x0C, C=0; done 4 cycles after accept.
- ROR data_in=0x01, count=7 -> result=0x02, C=0; done exactly 8 cycles after accept; busy high for 8 cycles.
- count=0 SHL 0xA5 -> done one cycle after accept, result=0xA5, C=0. Start asserted with 0xFF during SHIFT of an SHL 0x0F count=2 -> ignored, result=0x3C.
- Hold behaviour: after done for SHL 0x40 count=2 (result=0x00, C=1, Z=1), keep start low for 10 cycles -> result/C/Z unchanged, done low. Then start SHR 0x80 count=7 -> result=0x01, C=0.
